// File: rtl/sm3_blk_asm.sv
// -----------------------------------------------------------------------------
// sm3_blk_asm
// Consumer end of the SM3 padding stream. Padded message words are collected
// into 512-bit blocks using a two-entry ping-pong buffer, so one block can fill
// while the other waits for the compression core. pad_ena_o throttles the
// padding core at block granularity, and protocol violations are recorded in
// sticky error flags.
//
// Word order: W0 sits at blk_d_o[511:480] and W15 at blk_d_o[31:0]. Within a
// beat, the most-significant 32 bits carry the lower-index word.
//
// INPT_DW must be 32 or 64 (one or two words per beat).
//
// Optional build macro: SM3_BLK_ASM_IDX_EN
//   defined   : blk_idx_o counts the blocks popped within the current message.
//               It saturates at all-ones and returns to 0 after the last block.
//   undefined : the counter is absent and blk_idx_o is tied to 0.
// -----------------------------------------------------------------------------
module sm3_blk_asm #(
    parameter int INPT_DW   = 32,
    parameter int BLK_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INPT_DW-1:0]   pad_d_i,
    input  logic                 pad_vld_i,
    input  logic                 pad_lst_i,
    output logic                 pad_ena_o,
    output logic [511:0]         blk_d_o,
    output logic                 blk_vld_o,
    output logic                 blk_lst_o,
    input  logic                 blk_rdy_i,
    output logic [BLK_CNT_W-1:0] blk_idx_o,
    output logic                 err_ovf_o,
    output logic                 err_lst_o
);

    localparam int         WPC           = INPT_DW / 32;
    localparam logic [4:0] WPC_INC       = 5'(WPC);
    localparam logic [4:0] WORDS_PER_BLK = 5'd16;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_FILL  = 2'd1,
        BUF_FULL  = 2'd2
    } buf_st_e;

    // Per-buffer state, current (_r) and next (_s).
    buf_st_e      buf_st_r  [2];
    buf_st_e      buf_st_s  [2];
    logic [511:0] buf_d_r   [2];
    logic [511:0] buf_d_s   [2];
    logic         buf_lst_r [2];
    logic         buf_lst_s [2];

    // Pointers and the word counter of the buffer being filled.
    logic         fill_ptr_r;
    logic         fill_ptr_s;
    logic         other_ptr_s;
    logic         head_ptr_r;
    logic         head_ptr_s;
    logic [4:0]   wcnt_r;
    logic [4:0]   wcnt_s;
    logic [4:0]   wcnt_sum_s;

    // Per-cycle events.
    logic         pop_s;
    logic         ovf_s;
    logic         lst_err_s;

    // Output registers.
    logic         blk_vld_r;
    logic         blk_lst_r;
    logic [511:0] blk_d_r;
    logic         pad_ena_r;
    logic         err_ovf_r;
    logic         err_lst_r;

    // Next-state logic: the pop of the head buffer and the write of one beat
    // into the fill buffer. Both may happen in the same cycle. They never
    // target the same buffer: a written buffer is never FULL, and only a
    // FULL buffer can be popped.
    always_comb begin
        buf_st_s    = buf_st_r;
        buf_d_s     = buf_d_r;
        buf_lst_s   = buf_lst_r;
        fill_ptr_s  = fill_ptr_r;
        head_ptr_s  = head_ptr_r;
        wcnt_s      = wcnt_r;
        wcnt_sum_s  = wcnt_r + WPC_INC;
        pop_s       = blk_vld_r & blk_rdy_i;
        ovf_s       = 1'b0;
        lst_err_s   = 1'b0;

        // Pop: the buffer returns to EMPTY with zeroed data, so that a later
        // short block reads zeros in its unwritten words.
        if (pop_s) begin
            buf_st_s[head_ptr_r]  = BUF_EMPTY;
            buf_d_s[head_ptr_r]   = 512'd0;
            buf_lst_s[head_ptr_r] = 1'b0;
            head_ptr_s            = ~head_ptr_r;
        end else begin
            head_ptr_s            = head_ptr_r;
        end

        // Write: a beat into a FULL target is dropped and leaves all state
        // untouched. This includes a target that is freed in this same cycle.
        if (pad_vld_i) begin
            if (buf_st_r[fill_ptr_r] == BUF_FULL) begin
                ovf_s = 1'b1;
            end else begin
                for (int w = 0; w < WPC; w++) begin
                    buf_d_s[fill_ptr_r][511 - 32 * (int'(wcnt_r) + w) -: 32] =
                        pad_d_i[INPT_DW - 1 - 32 * w -: 32];
                end
                if (pad_lst_i || (wcnt_sum_s == WORDS_PER_BLK)) begin
                    buf_st_s[fill_ptr_r]  = BUF_FULL;
                    buf_lst_s[fill_ptr_r] = pad_lst_i;
                    wcnt_s                = 5'd0;
                    fill_ptr_s            = ~fill_ptr_r;
                    lst_err_s             = pad_lst_i && (wcnt_sum_s != WORDS_PER_BLK);
                end else begin
                    buf_st_s[fill_ptr_r]  = BUF_FILL;
                    wcnt_s                = wcnt_sum_s;
                end
            end
        end else begin
            ovf_s = 1'b0;
        end

        other_ptr_s = ~fill_ptr_s;
    end

    // Buffer state, data, pointers and word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_st_r[i]  <= BUF_EMPTY;
                buf_d_r[i]   <= 512'd0;
                buf_lst_r[i] <= 1'b0;
            end
            fill_ptr_r <= 1'b0;
            head_ptr_r <= 1'b0;
            wcnt_r     <= 5'd0;
        end else begin
            buf_st_r   <= buf_st_s;
            buf_d_r    <= buf_d_s;
            buf_lst_r  <= buf_lst_s;
            fill_ptr_r <= fill_ptr_s;
            head_ptr_r <= head_ptr_s;
            wcnt_r     <= wcnt_s;
        end
    end

    // Output registers, loaded from the next state. A block completed at an
    // edge is therefore presented right after that edge, and pad_ena_o tracks
    // the buffer occupancy without an extra cycle of lag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_vld_r <= 1'b0;
            blk_lst_r <= 1'b0;
            blk_d_r   <= 512'd0;
            pad_ena_r <= 1'b1;
        end else begin
            blk_vld_r <= (buf_st_s[head_ptr_s] == BUF_FULL);
            blk_lst_r <= buf_lst_s[head_ptr_s] && (buf_st_s[head_ptr_s] == BUF_FULL);
            blk_d_r   <= buf_d_s[head_ptr_s];
            pad_ena_r <= (buf_st_s[other_ptr_s] == BUF_EMPTY) ||
                         (buf_st_s[fill_ptr_s] == BUF_EMPTY);
        end
    end

    // Sticky protocol error flags; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf_r <= 1'b0;
            err_lst_r <= 1'b0;
        end else begin
            err_ovf_r <= err_ovf_r | ovf_s;
            err_lst_r <= err_lst_r | lst_err_s;
        end
    end

`ifdef SM3_BLK_ASM_IDX_EN
    logic [BLK_CNT_W-1:0] blk_idx_r;

    // Block index within the message: it steps on each pop, saturates at
    // all-ones and restarts after the last block of a message.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_idx_r <= {BLK_CNT_W{1'b0}};
        end else if (pop_s) begin
            if (blk_lst_r) begin
                blk_idx_r <= {BLK_CNT_W{1'b0}};
            end else if (blk_idx_r != {BLK_CNT_W{1'b1}}) begin
                blk_idx_r <= blk_idx_r + BLK_CNT_W'(1);
            end else begin
                blk_idx_r <= blk_idx_r;
            end
        end else begin
            blk_idx_r <= blk_idx_r;
        end
    end

    assign blk_idx_o = blk_idx_r;
`else
    assign blk_idx_o = {BLK_CNT_W{1'b0}};
`endif

    assign blk_vld_o = blk_vld_r;
    assign blk_lst_o = blk_lst_r;
    assign blk_d_o   = blk_d_r;
    assign pad_ena_o = pad_ena_r;
    assign err_ovf_o = err_ovf_r;
    assign err_lst_o = err_lst_r;

endmodule

// File: tb/tb_sm3_blk_asm.sv
// -----------------------------------------------------------------------------
// tb_sm3_blk_asm
// Self-checking bench for sm3_blk_asm. It uses a 32-bit and a 64-bit instance.
// There are four kinds of checks:
//   - a per-cycle vector table for single-block and short-last behaviour;
//   - hand sequences for back-pressure, overflow, block index and async reset;
//   - a randomized message stream scored against expected block contents,
//     which are built from the message words;
//   - reset-state checks.
// Honours SM3_BLK_ASM_IDX_EN for the expected block index.
// -----------------------------------------------------------------------------
module tb_sm3_blk_asm;

    logic         clk = 1'b0;
    logic         rst_n;

    logic [31:0]  d32;
    logic         vld32, lst32, rdy32, ena32, bv32, bl32, eo32, el32;
    logic [511:0] bd32;
    logic [15:0]  idx32;

    logic [63:0]  d64;
    logic         vld64, lst64, rdy64, ena64, bv64, bl64, eo64, el64;
    logic [511:0] bd64;
    logic [15:0]  idx64;

    int n_cmp = 0;
    int n_bad = 0;

    sm3_blk_asm #(.INPT_DW(32), .BLK_CNT_W(16)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .pad_d_i(d32), .pad_vld_i(vld32), .pad_lst_i(lst32),
        .pad_ena_o(ena32), .blk_d_o(bd32), .blk_vld_o(bv32), .blk_lst_o(bl32),
        .blk_rdy_i(rdy32), .blk_idx_o(idx32), .err_ovf_o(eo32), .err_lst_o(el32)
    );

    sm3_blk_asm #(.INPT_DW(64), .BLK_CNT_W(16)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .pad_d_i(d64), .pad_vld_i(vld64), .pad_lst_i(lst64),
        .pad_ena_o(ena64), .blk_d_o(bd64), .blk_vld_o(bv64), .blk_lst_o(bl64),
        .blk_rdy_i(rdy64), .blk_idx_o(idx64), .err_ovf_o(eo64), .err_lst_o(el64)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  d;
        logic         vld;
        logic         lst;
        logic         rdy;
        logic         ev;
        logic         el;
        logic         ee;
        logic         eerr;
        logic         chk_d;
        logic [511:0] ed;
    } vec_t;

    vec_t tbl [24];

    // Random-stream scoreboard storage.
    logic [31:0]  rb_w   [64][16];
    logic [511:0] rb_d   [64];
    logic         rb_lst [64];
    int           rb_nw  [64];
    int           rb_idx [64];
    int           nblk, pi, bi, ci, cyc, nb, nw;
    logic [511:0] exp_a, exp_b, exp_s;

    task automatic chk_b(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_w(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Block whose first n words count up from base; the remaining words are zero.
    function automatic logic [511:0] mk_blk(input logic [31:0] base, input int n);
        logic [511:0] b;
        b = 512'd0;
        for (int k = 0; k < n; k++) begin
            b[511 - 32 * k -: 32] = base + 32'(k);
        end
        return b;
    endfunction

    function automatic int exp_idx(input int pos);
`ifdef SM3_BLK_ASM_IDX_EN
        return pos;
`else
        return 0 * pos;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat32(input logic [31:0] d, input logic l);
        d32   = d;
        vld32 = 1'b1;
        lst32 = l;
        step();
        d32   = 32'd0;
        vld32 = 1'b0;
        lst32 = 1'b0;
    endtask

    task automatic send_blk32(input logic [31:0] base, input logic l, input int pos);
        for (int k = 0; k < 16; k++) begin
            beat32(base + 32'(k), l && (k == 15));
        end
        chk_b("idx_vld", bv32, 1'b1);
        chk_b("idx_lst", bl32, l);
        chk_i("idx_val", int'(idx32), exp_idx(pos));
        chk_w("idx_data", bd32, mk_blk(base, 16));
    endtask

    initial begin
        rst_n = 1'b0;
        d32 = 32'd0; vld32 = 1'b0; lst32 = 1'b0; rdy32 = 1'b0;
        d64 = 64'd0; vld64 = 1'b0; lst64 = 1'b0; rdy64 = 1'b1;

        exp_a = mk_blk(32'd1, 16);
        exp_s = mk_blk(32'hA0, 5);
        for (int k = 0; k < 16; k++) begin
            tbl[k] = '{d: 32'(k + 1), vld: 1'b1, lst: (k == 15), rdy: 1'b1,
                       ev: (k == 15), el: (k == 15), ee: 1'b1, eerr: 1'b0,
                       chk_d: (k == 15), ed: exp_a};
        end
        tbl[16] = '{d: 32'd0, vld: 1'b0, lst: 1'b0, rdy: 1'b1, ev: 1'b0, el: 1'b0,
                    ee: 1'b1, eerr: 1'b0, chk_d: 1'b0, ed: 512'd0};
        for (int j = 0; j < 5; j++) begin
            tbl[17 + j] = '{d: 32'hA0 + 32'(j), vld: 1'b1, lst: (j == 4), rdy: 1'b0,
                            ev: (j == 4), el: (j == 4), ee: 1'b1, eerr: (j == 4),
                            chk_d: (j == 4), ed: exp_s};
        end
        tbl[22] = '{d: 32'd0, vld: 1'b0, lst: 1'b0, rdy: 1'b0, ev: 1'b1, el: 1'b1,
                    ee: 1'b1, eerr: 1'b1, chk_d: 1'b1, ed: exp_s};
        tbl[23] = '{d: 32'd0, vld: 1'b0, lst: 1'b0, rdy: 1'b1, ev: 1'b0, el: 1'b0,
                    ee: 1'b1, eerr: 1'b1, chk_d: 1'b0, ed: 512'd0};

        // Reset state of both instances.
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_b("rst_vld32", bv32, 1'b0);
        chk_b("rst_lst32", bl32, 1'b0);
        chk_w("rst_d32", bd32, 512'd0);
        chk_b("rst_ena32", ena32, 1'b1);
        chk_b("rst_ovf32", eo32, 1'b0);
        chk_b("rst_errl32", el32, 1'b0);
        chk_i("rst_idx32", int'(idx32), 0);
        chk_b("rst_vld64", bv64, 1'b0);
        chk_b("rst_ena64", ena64, 1'b1);

        // Table: one full 16-word block, then a short-last block held under back-pressure.
        for (int i = 0; i < 24; i++) begin
            d32 = tbl[i].d; vld32 = tbl[i].vld; lst32 = tbl[i].lst; rdy32 = tbl[i].rdy;
            step();
            chk_b($sformatf("tbl%0d_vld", i), bv32, tbl[i].ev);
            chk_b($sformatf("tbl%0d_lst", i), bl32, tbl[i].el);
            chk_b($sformatf("tbl%0d_ena", i), ena32, tbl[i].ee);
            chk_b($sformatf("tbl%0d_errl", i), el32, tbl[i].eerr);
            if (tbl[i].chk_d) begin
                chk_w($sformatf("tbl%0d_data", i), bd32, tbl[i].ed);
            end
        end
        d32 = 32'd0; vld32 = 1'b0; lst32 = 1'b0; rdy32 = 1'b0;

        // 64-bit beats: the upper half carries the lower-index word.
        for (int k = 0; k < 8; k++) begin
            d64 = {32'(2 * k + 1), 32'(2 * k + 2)};
            vld64 = 1'b1;
            lst64 = (k == 7);
            step();
            if (k == 6) chk_b("w64_early_vld", bv64, 1'b0);
        end
        vld64 = 1'b0; lst64 = 1'b0;
        chk_b("w64_vld", bv64, 1'b1);
        chk_b("w64_lst", bl64, 1'b1);
        chk_w("w64_hi", 512'(bd64[511:448]), 512'(64'h00000001_00000002));
        chk_w("w64_data", bd64, exp_a);
        step();
        chk_b("w64_popped", bv64, 1'b0);

        // Back-pressure with two blocks, then an overflow beat.
        exp_a = mk_blk(32'h100, 16);
        exp_b = mk_blk(32'h200, 16);
        rdy32 = 1'b0;
        for (int k = 0; k < 16; k++) beat32(32'h100 + 32'(k), 1'b0);
        chk_b("bp_a_vld", bv32, 1'b1);
        chk_b("bp_a_lst", bl32, 1'b0);
        chk_b("bp_a_ena", ena32, 1'b1);
        for (int k = 0; k < 16; k++) begin
            beat32(32'h200 + 32'(k), (k == 15));
            if (k == 0) chk_b("bp_b_fill_ena", ena32, 1'b0);
        end
        chk_b("bp_b_ena", ena32, 1'b0);
        chk_w("bp_head_a", bd32, exp_a);
        step();
        step();
        chk_w("bp_hold_a", bd32, exp_a);
        chk_b("bp_hold_vld", bv32, 1'b1);
        beat32(32'hDEADBEEF, 1'b0);
        chk_b("ovf_set", eo32, 1'b1);
        chk_w("ovf_a_kept", bd32, exp_a);
        chk_b("ovf_ena", ena32, 1'b0);
        step();
        chk_b("ovf_sticky", eo32, 1'b1);
        rdy32 = 1'b1;
        step();
        chk_b("pop1_vld", bv32, 1'b1);
        chk_b("pop1_lst", bl32, 1'b1);
        chk_w("pop1_b", bd32, exp_b);
        chk_b("pop1_ena", ena32, 1'b1);
        chk_i("pop1_idx", int'(idx32), exp_idx(1));
        step();
        chk_b("pop2_vld", bv32, 1'b0);
        chk_i("pop2_idx", int'(idx32), 0);
        chk_b("pop2_ovf", eo32, 1'b1);

        // Block index: a 3-block message, then a 1-block message, streamed with rdy=1.
        send_blk32(32'h1000, 1'b0, 0);
        send_blk32(32'h2000, 1'b0, 1);
        send_blk32(32'h3000, 1'b1, 2);
        send_blk32(32'h4000, 1'b1, 0);
        step();
        chk_b("idx_end_vld", bv32, 1'b0);
        chk_i("idx_end", int'(idx32), 0);
        rdy32 = 1'b0;

        // Async reset in the middle of a block discards the partial data.
        for (int k = 0; k < 5; k++) beat32(32'h300 + 32'(k), 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_b("arst_vld", bv32, 1'b0);
        chk_b("arst_ena", ena32, 1'b1);
        chk_b("arst_ovf", eo32, 1'b0);
        chk_b("arst_errl", el32, 1'b0);
        chk_w("arst_d", bd32, 512'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 16; k++) beat32(32'h400 + 32'(k), (k == 15));
        chk_b("arst_blk_vld", bv32, 1'b1);
        chk_w("arst_blk_data", bd32, mk_blk(32'h400, 16));
        rdy32 = 1'b1;
        step();
        chk_b("arst_blk_pop", bv32, 1'b0);

        // Randomized stream: messages of 1..4 blocks; the last block is 1..16 words.
        nblk = 0;
        for (int m = 0; m < 12; m++) begin
            nb = int'($urandom_range(1, 4));
            for (int b = 0; b < nb; b++) begin
                nw = (b == nb - 1) ? int'($urandom_range(1, 16)) : 16;
                rb_nw[nblk]  = nw;
                rb_lst[nblk] = (b == nb - 1);
                rb_idx[nblk] = exp_idx(b);
                rb_d[nblk]   = 512'd0;
                for (int w = 0; w < nw; w++) begin
                    rb_w[nblk][w] = $urandom;
                    rb_d[nblk][511 - 32 * w -: 32] = rb_w[nblk][w];
                end
                nblk++;
            end
        end
        pi = 0; bi = 0; ci = 0; cyc = 0;
        while (ci < nblk && cyc < 20000) begin
            rdy32 = ($urandom_range(0, 3) != 0);
            if (bv32 && rdy32) begin
                chk_w($sformatf("rnd%0d_data", ci), bd32, rb_d[ci]);
                chk_b($sformatf("rnd%0d_lst", ci), bl32, rb_lst[ci]);
                chk_i($sformatf("rnd%0d_idx", ci), int'(idx32), rb_idx[ci]);
                ci++;
            end
            d32 = 32'd0; vld32 = 1'b0; lst32 = 1'b0;
            if (pi < nblk && (bi > 0 || ena32) && $urandom_range(0, 4) != 0) begin
                d32   = rb_w[pi][bi];
                vld32 = 1'b1;
                lst32 = rb_lst[pi] && (bi == rb_nw[pi] - 1);
                bi++;
                if (bi == rb_nw[pi]) begin
                    pi++;
                    bi = 0;
                end
            end
            step();
            cyc++;
        end
        d32 = 32'd0; vld32 = 1'b0; lst32 = 1'b0; rdy32 = 1'b0;
        chk_i("rnd_blocks_seen", ci, nblk);
        chk_b("rnd_no_ovf", eo32, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
